l1_dcache_setassoc: RTL and testbench
=====================================

// Module: l1_dcache_setassoc
// PURPOSE
//  Parametrised L1 data cache between the pipelined core's MEM stage and a word-beat backing memory.
//  - Geometry: set-associative (1 or 2 ways).
//  - Policy: write-back, write-allocate; LRU replacement when 2-way.
//  - Hits complete in the requesting cycle. Misses raise cpu_stall; the core freezes all stages
//    and holds the request stable until cpu_stall falls.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  word width; cpu_be width is DATA_W/8
//  LINE_WORDS  4   words per line (power of 2, >=2)
//  SETS        64  sets (power of 2)
//  WAYS        2   associativity, 1 or 2 only
// PORTS
//  clock      in   1         clock, rising edge
//  reset      in   1         reset, asynchronous, active-low
//  cpu_rd     in   1         load request
//  cpu_wr     in   1         store request (wins if cpu_rd also high)
//  cpu_addr   in   ADDR_W    byte address; bits[1:0] ignored
//  cpu_wdata  in   DATA_W    store data
//  cpu_be     in   DATA_W/8  store byte enables
//  cpu_rdata  out  DATA_W    load data, valid when cpu_rd & ~cpu_stall
//  cpu_stall  out  1         request not complete; core must hold
//  mem_req    out  1         beat request, held until mem_ack
//  mem_we     out  1         1 = write-back beat, 0 = refill beat
//  mem_addr   out  ADDR_W    word-aligned beat address
//  mem_wdata  out  DATA_W    write-back beat data
//  mem_ack    in   1         beat accepted (write) / mem_rdata valid (read)
//  mem_rdata  in   DATA_W    refill beat data
// BEHAVIOUR
//  - Address split: offset = 2+log2(LINE_WORDS) bits, index = log2(SETS) bits, tag = remaining bits.
//  - Reset, asynchronous:
//    - Clears all valid, dirty and LRU bits; state IDLE; beat counter 0.
//    - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_stall=0.
//    - Reset mid-burst abandons the burst; the line is not installed.
//  - Lookup is combinational in IDLE. Hit = valid & tag match in any way.
//    - Read hit: cpu_rdata = word, cpu_stall=0, same cycle.
//    - Write hit: the bytes enabled by cpu_be are updated at the next posedge; dirty set.
//  - cpu_stall = (cpu_rd|cpu_wr) & (~hit | state!=IDLE). Combinational, same cycle as the request.
//  - Victim selection: first invalid way (way0 first); otherwise the LRU way. WAYS=1 always uses way0.
//  - LRU (1 bit per set) points to the non-accessed way after every hit and every refill.
//  - FSM:
//    - IDLE->WB: on a miss with a dirty victim.
//    - IDLE->FILL: on a miss with a clean victim.
//    - WB->FILL: after LINE_WORDS acks.
//    - FILL->IDLE: after LINE_WORDS acks.
//  - Beats:
//    - mem_addr = line base + 4*beat; beat runs 0..LINE_WORDS-1 and increments only on mem_ack.
//    - mem_req stays high through WB and FILL.
//    - mem_addr, mem_we and mem_wdata are stable while mem_req & ~mem_ack.
//    - mem_req drops in the cycle after the last FILL ack.
//  - WB: mem_we=1, victim tag/index base, mem_wdata = victim word[beat].
//  - FILL: mem_we=0, requested line base; mem_rdata is written into word[beat] on each ack.
//  - Line install: on the last FILL ack the line becomes valid, dirty=0, tag written.
//  - Retry after refill: the following cycle (IDLE) re-looks-up and hits. A store then merges
//    and sets dirty, so a write miss ends as a write hit.
//  - Miss latency with 0-wait memory: 1 + LINE_WORDS (clean) or 1 + 2*LINE_WORDS (dirty)
//    cycles of stall.
//  - Requests arriving while state!=IDLE are ignored other than stalling.
//  - The bypass network needs no awareness of the cache because the whole pipeline freezes on stall.
// TESTING
//  - Cold read 0x100: stall; FILL beats at 0x100,0x104,0x108,0x10C (mem_rdata 0xA0..0xA3); stall
//    drops and cpu_rdata=0xA0. Read 0x104 next: hit, stall=0, rdata=0xA1.
//  - Write 0xAABBCCDD, be=4'b0011 to a cached 0x11223344 -> later read returns 0x1122CCDD; line dirty.
//  - WAYS=2: store 0x100, read 0x500, read 0x900 (same set) -> WB 4 beats mem_we=1 0x100..0x10C
//    with dirty data, then FILL 0x900..0x90C; read 0x500 still hits.
//  - WAYS=1: read 0x100 then 0x500 -> 0x100 evicted without WB (clean); read 0x100 misses again.
//  - Random 0-5 cycle mem_ack delay -> stall held, mem_addr/mem_we/mem_wdata stable until ack;
//    data identical to 0-wait run.
//  - Assert reset during beat 2 of FILL -> mem_req=0, cpu_stall=0 immediately; re-read of the
//    same address misses and refills all 4 beats.

Source files
------------

// File: rtl/l1_dcache_setassoc.sv
`default_nettype none
// =============================================================================
// l1_dcache_setassoc : write-back / write-allocate L1 data cache, 1- or 2-way LRU
// Revision 1.0
// =============================================================================
module l1_dcache_setassoc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = 2 + WORD_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BE_W   = DATA_W / 8;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] beat_q;
  logic              way_q;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [SETS-1:0]   lru_q;
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_word;
  logic [WAYS-1:0]   w_hit_vec;
  logic              w_hit;
  logic              w_hit_way;
  logic              w_victim;
  logic              w_idle;
  logic              w_req;
  logic              w_lookup_hit;
  logic              w_store_hit;
  logic              w_fill_we;
  logic              w_fill_last;
  logic [TAG_W-1:0]  w_line_tag;
  logic              w_unused;

  assign w_tag    = cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_idx    = cpu_addr[OFF_W +: IDX_W];
  assign w_word   = cpu_addr[2 +: WORD_W];
  assign w_unused = &{1'b0, cpu_addr[1:0]};

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = valid_q[w][w_idx] && (tag_q[w][w_idx] == w_tag);
    end
  end
  assign w_hit = |w_hit_vec;

  // Victim: an empty way first (way0 before way1), otherwise the LRU way.
  generate
    if (WAYS == 2) begin : g_two_way
      assign w_hit_way = w_hit_vec[1];
      assign w_victim  = !valid_q[0][w_idx] ? 1'b0 :
                         !valid_q[1][w_idx] ? 1'b1 : lru_q[w_idx];
    end else begin : g_one_way
      assign w_hit_way = 1'b0;
      assign w_victim  = 1'b0;
    end
  endgenerate

  assign w_idle       = (state_q == S_IDLE);
  assign w_req        = cpu_rd || cpu_wr;
  assign w_lookup_hit = w_idle && w_hit;
  assign w_store_hit  = w_lookup_hit && cpu_wr;
  assign w_fill_we    = (state_q == S_FILL) && mem_ack;
  assign w_fill_last  = w_fill_we && (beat_q == LAST_BEAT);

  // Stall is masked while reset is held so a frozen core sees a quiet cache.
  assign cpu_stall = reset && w_req && !w_lookup_hit;
  assign cpu_rdata = w_lookup_hit ? data_q[w_hit_way][w_idx][w_word] : '0;

  assign mem_req    = !w_idle;
  assign mem_we     = (state_q == S_WB);
  assign w_line_tag = mem_we ? tag_q[way_q][miss_idx_q] : miss_tag_q;
  assign mem_addr   = mem_req ? {w_line_tag, miss_idx_q, beat_q, 2'b00} : '0;
  assign mem_wdata  = mem_we ? data_q[way_q][miss_idx_q][beat_q] : '0;

  always_ff @(posedge clock) begin
    if (w_fill_we) begin
      data_q[way_q][miss_idx_q][beat_q] <= mem_rdata;
    end
    if (w_store_hit) begin
      for (int b = 0; b < BE_W; b++) begin
        if (cpu_be[b]) begin
          data_q[w_hit_way][w_idx][w_word][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
    if (w_fill_last) begin
      tag_q[way_q][miss_idx_q] <= miss_tag_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      way_q      <= 1'b0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      lru_q      <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              lru_q[w_idx] <= ~w_hit_way;
              if (cpu_wr) begin
                dirty_q[w_hit_way][w_idx] <= 1'b1;
              end
            end else begin
              way_q      <= w_victim;
              miss_tag_q <= w_tag;
              miss_idx_q <= w_idx;
              beat_q     <= '0;
              state_q    <= dirty_q[w_victim][w_idx] ? S_WB : S_FILL;
            end
          end
        end
        S_WB: begin
          if (mem_ack) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
              valid_q[way_q][miss_idx_q] <= 1'b1;
              dirty_q[way_q][miss_idx_q] <= 1'b0;
              lru_q[miss_idx_q]          <= ~way_q;
              state_q                    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_l1_dcache_setassoc.sv
`default_nettype none
// tb_l1_dcache_setassoc : directed vector table, reset-during-refill sequence and a randomized run
// checked against an LRU line-list model plus a word-level view of memory.
module tb_l1_dcache_setassoc;
  localparam int LW    = 4;
  localparam int NSETS = 64;
  localparam int NWAYS = 2;

  logic        clock, reset, cpu_rd, cpu_wr, cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  cpu_be;

  l1_dcache_setassoc #(
    .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .SETS(NSETS), .WAYS(NWAYS)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;
  int max_delay = 0;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;
  beat_t       beats[$];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] vmem [logic [31:0]];

  // Model: per set, resident line tags ordered most- to least-recently used.
  int unsigned m_tag   [NSETS][NWAYS];
  bit          m_dirty [NSETS][NWAYS];
  int          m_cnt   [NSETS];

  typedef struct {
    bit rd; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
    bit exp_hit; int exp_wb; logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [12];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] back_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : (a ^ 32'hDEAD_0000);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return vmem.exists(a) ? vmem[a] : back_rd(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) m_cnt[s] = 0;
    vmem.delete();
  endtask

  // Backing memory: random 0..max_delay cycle ack per beat; checks beat signals hold until ack.
  initial begin : responder
    bit          in_beat;
    int          wait_left;
    logic [64:0] cap;
    in_beat = 1'b0; wait_left = 0; cap = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ack = 1'b0;
      if (mem_req && reset) begin
        if (!in_beat) begin
          in_beat   = 1'b1;
          cap       = {mem_we, mem_addr, mem_wdata};
          wait_left = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
        end else begin
          chk("mem_hold", {mem_we, mem_addr, mem_wdata}, cap);
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          in_beat = 1'b0;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = back_rd(mem_addr);
          beats.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
        end else begin
          wait_left--;
        end
      end else begin
        in_beat = 1'b0;
      end
    end
  end

  // One CPU request, held until stall falls; checked against the model, then the model advances.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output bit o_hit, output logic [31:0] o_rdata,
                        output int o_wb);
    int          s, pos, top, n, n_wb, exp_beats, exp_n;
    bit          m_hit, ev_dirty, done, d;
    logic [31:0] tag, base, ev_base, w;
    beat_t       b;
    s    = int'(a[9:4]);
    tag  = a >> 10;
    base = a & ~32'hF;
    pos  = -1;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == tag) pos = i;
    m_hit     = (pos >= 0);
    ev_dirty  = !m_hit && (m_cnt[s] == NWAYS) && m_dirty[s][NWAYS-1];
    ev_base   = {m_tag[s][NWAYS-1][21:0], a[9:4], 4'h0};
    n_wb      = ev_dirty ? LW : 0;
    exp_beats = m_hit ? 0 : LW + n_wb;
    exp_n     = m_hit ? 0 : 1 + exp_beats;

    beats.delete();
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    n = 0; done = 1'b0; o_rdata = '0;
    while (!done && n <= 400) begin
      @(negedge clock);
      if (!cpu_stall) begin
        o_rdata = cpu_rdata;
        done    = 1'b1;
      end else begin
        n++;
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;

    chk("req_done", 65'(done), 65'(1));
    o_hit = (n == 0);
    o_wb  = 0;
    foreach (beats[i]) if (beats[i].we) o_wb++;
    if (rd && !wr) chk($sformatf("rdata@%0h", a), 65'(o_rdata), 65'(ref_rd(a)));
    chk($sformatf("hit@%0h", a), 65'(o_hit), 65'(m_hit));
    if (max_delay == 0) chk("stall_cycles", 65'(n), 65'(exp_n));
    chk("beat_count", 65'(beats.size()), 65'(exp_beats));
    for (int i = 0; i < beats.size() && i < exp_beats; i++) begin
      b = beats[i];
      if (i < n_wb) begin
        chk("wb_beat", {b.we, b.addr, b.data},
            {1'b1, ev_base + 32'(4*i), ref_rd(ev_base + 32'(4*i))});
      end else begin
        chk("fill_beat", 65'({b.we, b.addr}), 65'({1'b0, base + 32'(4*(i-n_wb))}));
      end
    end

    d   = wr;
    top = m_hit ? pos : ((m_cnt[s] < NWAYS) ? m_cnt[s] : NWAYS-1);
    if (m_hit) d = d | m_dirty[s][pos];
    else if (m_cnt[s] < NWAYS) m_cnt[s]++;
    for (int i = top; i > 0; i--) begin
      m_tag[s][i]   = m_tag[s][i-1];
      m_dirty[s][i] = m_dirty[s][i-1];
    end
    m_tag[s][0]   = tag;
    m_dirty[s][0] = d;
    if (wr) begin
      w = ref_rd(a);
      for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
      vmem[a] = w;
    end
  endtask

  initial begin : stim
    bit          d_hit;
    logic [31:0] d_rdata, a;
    int          d_wb, k, op;

    tbl[0]  = '{1, 0, 32'h100,  32'h0,        4'h0, 0, 0, 32'hA0};
    tbl[1]  = '{1, 0, 32'h104,  32'h0,        4'h0, 1, 0, 32'hA1};
    tbl[2]  = '{0, 1, 32'h10C,  32'h11223344, 4'hF, 1, 0, 32'h0};
    tbl[3]  = '{0, 1, 32'h10C,  32'hAABBCCDD, 4'h3, 1, 0, 32'h0};
    tbl[4]  = '{1, 0, 32'h10C,  32'h0,        4'h0, 1, 0, 32'h1122CCDD};
    tbl[5]  = '{1, 0, 32'h500,  32'h0,        4'h0, 0, 0, 32'hDEAD0500};
    tbl[6]  = '{1, 0, 32'h900,  32'h0,        4'h0, 0, 4, 32'hDEAD0900};
    tbl[7]  = '{1, 0, 32'h500,  32'h0,        4'h0, 1, 0, 32'hDEAD0500};
    tbl[8]  = '{1, 0, 32'h10C,  32'h0,        4'h0, 0, 0, 32'h1122CCDD};
    tbl[9]  = '{1, 0, 32'h108,  32'h0,        4'h0, 1, 0, 32'hA2};
    tbl[10] = '{0, 1, 32'h2000, 32'h12345678, 4'hF, 0, 0, 32'h0};
    tbl[11] = '{1, 0, 32'h2000, 32'h0,        4'h0, 1, 0, 32'h12345678};
    for (int i = 0; i < LW; i++) bmem[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);

    reset = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("reset_stall",  65'(cpu_stall), 65'(0));
    chk("reset_req",    65'(mem_req),   65'(0));
    chk("reset_we",     65'(mem_we),    65'(0));
    chk("reset_addr",   65'(mem_addr),  65'(0));
    chk("reset_wdata",  65'(mem_wdata), 65'(0));
    chk("reset_rdata",  65'(cpu_rdata), 65'(0));
    @(posedge clock); #1;

    foreach (tbl[i]) begin
      do_req(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, d_hit, d_rdata, d_wb);
      chk($sformatf("tbl%0d_hit", i), 65'(d_hit), 65'(tbl[i].exp_hit));
      chk($sformatf("tbl%0d_wb", i), 65'(d_wb), 65'(tbl[i].exp_wb));
      if (tbl[i].rd && !tbl[i].wr)
        chk($sformatf("tbl%0d_rdata", i), 65'(d_rdata), 65'(tbl[i].exp_rdata));
    end

    // Reset while refill beat 2 is outstanding: the line must not survive.
    cpu_rd = 1'b1; cpu_addr = 32'h3040;
    k = 0;
    while (k < 50 && !(mem_req && !mem_we && mem_addr == 32'h3048)) begin
      @(posedge clock); #1; k++;
    end
    chk("fill_beat2_reached", 65'(mem_addr), 65'(32'h3048));
    reset = 1'b0;
    #1;
    chk("midrst_req",   65'(mem_req),   65'(0));
    chk("midrst_stall", 65'(cpu_stall), 65'(0));
    chk("midrst_addr",  65'(mem_addr),  65'(0));
    cpu_rd = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    do_req(1, 0, 32'h3040, 32'h0, 4'h0, d_hit, d_rdata, d_wb);
    chk("rerd_hit",   65'(d_hit),   65'(0));
    chk("rerd_rdata", 65'(d_rdata), 65'(32'h3040 ^ 32'hDEAD_0000));

    // Randomized traffic in two conflicting sets, first with slow memory, then 0-wait.
    for (int i = 0; i < 320; i++) begin
      max_delay = (i < 250) ? 5 : 0;
      op = int'($urandom_range(2, 0));
      a  = (32'($urandom_range(3, 0)) << 10) | (32'($urandom_range(1, 0)) << 4) |
           (32'($urandom_range(3, 0)) << 2);
      do_req(op != 1, op != 0, a, $urandom, 4'($urandom), d_hit, d_rdata, d_wb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
